// File: rtl/llr_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : llr_frame_loader
//  Description : Serial LLR stream -> saturated, ping-pong frame banks that
//                are presented to the LDPC decoder as a parallel frame.
//  Revision    : 1.0  initial release
// ============================================================================
module llr_frame_loader #(
  parameter int data_w = 8,
  parameter int in_w   = 12,
  parameter int R      = 24,
  parameter int D      = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [in_w-1:0]        in_llr,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [R*D*data_w-1:0]  sig,
  output logic                   sig_valid,
  input  logic                   sig_take,
  output logic                   err_len,
  output logic [15:0]            frame_cnt
);

  localparam int c_n       = R * D;
  localparam int c_idx_w   = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_frame_w = c_n * data_w;
  localparam int c_base_w  = $clog2(c_frame_w);

  localparam logic [c_idx_w-1:0]     c_last_idx = c_idx_w'(c_n - 1);
  localparam logic signed [in_w-1:0] c_pos_max  = in_w'((2 ** (data_w - 1)) - 1);
  localparam logic signed [in_w-1:0] c_neg_max  = -c_pos_max;

  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [1:0]             r_bank_full;
  logic [c_idx_w-1:0]     r_wr_idx;
  logic [c_frame_w-1:0]   r_bank0;
  logic [c_frame_w-1:0]   r_bank1;
  logic                   r_err_len;
  logic [15:0]            r_frame_cnt;

  logic signed [in_w-1:0] w_llr;
  logic [data_w-1:0]      w_sat;
  logic                   w_accept;
  logic                   w_frame_end;
  logic                   w_short;
  logic                   w_write;
  logic                   w_take;
  logic [1:0]             w_full_set;
  logic [1:0]             w_full_clr;
  logic [c_base_w-1:0]    w_base;

  // Symmetric saturation: the most negative code is never produced
  assign w_llr = in_llr;
  always_comb begin
    if (w_llr > c_pos_max)
      w_sat = c_pos_max[data_w-1:0];
    else if (w_llr < c_neg_max)
      w_sat = c_neg_max[data_w-1:0];
    else
      w_sat = w_llr[data_w-1:0];
  end

  assign in_ready    = ~r_bank_full[r_wr_bank];
  assign w_accept    = in_valid & in_ready;
  assign w_frame_end = w_accept & (r_wr_idx == c_last_idx);
  assign w_short     = w_accept & in_last & ~w_frame_end;
  assign w_write     = w_accept & ~w_short;
  assign w_take      = sig_take & sig_valid;
  assign w_base      = c_base_w'(r_wr_idx * data_w);

  // A completing write and a take always hit different banks
  always_comb begin
    w_full_set = 2'b00;
    w_full_clr = 2'b00;
    if (w_frame_end)
      w_full_set[r_wr_bank] = 1'b1;
    if (w_take)
      w_full_clr[r_rd_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_wr_idx    <= '0;
      r_err_len   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_err_len   <= 1'b0;
      r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
      if (w_accept) begin
        if (w_frame_end) begin
          r_wr_idx    <= '0;
          r_wr_bank   <= ~r_wr_bank;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_err_len   <= ~in_last;
        end else if (in_last) begin
          r_wr_idx  <= '0;
          r_err_len <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_take)
        r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else if (w_write) begin
      if (r_wr_bank)
        r_bank1[w_base +: data_w] <= w_sat;
      else
        r_bank0[w_base +: data_w] <= w_sat;
    end
  end

  assign sig       = r_rd_bank ? r_bank1 : r_bank0;
  assign sig_valid = r_bank_full[r_rd_bank];
  assign err_len   = r_err_len;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_llr_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_llr_frame_loader
//  Description : Directed self-checking bench for llr_frame_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_llr_frame_loader;

  localparam int c_n = 576;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   in_llr = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [4607:0] sig;
  logic          sig_valid;
  logic          sig_take = 1'b0;
  logic          err_len;
  logic [15:0]   frame_cnt;

  logic [11:0]   stim [c_n];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            t0;

  llr_frame_loader #(.data_w(8), .in_w(12), .R(24), .D(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_llr    (in_llr),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sig       (sig),
    .sig_valid (sig_valid),
    .sig_take  (sig_take),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slot(input int k);
    return sig[k*8 +: 8];
  endfunction

  task automatic fill_ramp(input logic [11:0] tag);
    for (int k = 0; k < c_n; k++) stim[k] = 12'(k - 288);
    stim[0] = tag;
  endtask

  // Called and returns at posedge+1; holds the sample until accepted
  task automatic push(input logic [11:0] v, input logic last, input logic take);
    int   waited;
    logic acc;
    waited = 0;
    in_llr = v; in_last = last; in_valid = 1'b1;
    forever begin
      acc = in_ready;
      sig_take = take;
      @(posedge clk); #1;
      sig_take = 1'b0;
      if (acc) break;
      waited++;
      if (waited > 64) begin
        chk("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_frame(input int len, input bit no_last, input bit take_on_last);
    for (int k = 0; k < len; k++)
      push(stim[k], (k == len - 1) && !no_last, (k == len - 1) && take_on_last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_frame();
    sig_take = 1'b1;
    @(posedge clk); #1;
    sig_take = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err_len",   32'(err_len),   32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_sig_zero",  32'(|sig),      32'd0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: ramp k-288, saturating at both ends
    fill_ramp(12'hEE0);
    t0 = cyc;
    send_frame(c_n, 1'b0, 1'b0);
    chk("t1_throughput", 32'(cyc - t0), 32'd576);
    chk("t1_sig_valid",  32'(sig_valid), 32'd1);
    chk("t1_slot0",      32'(slot(0)),   32'h81);
    chk("t1_slot100",    32'(slot(100)), 32'h81);
    chk("t1_slot288",    32'(slot(288)), 32'h00);
    chk("t1_slot400",    32'(slot(400)), 32'h70);
    chk("t1_slot575",    32'(slot(575)), 32'h7F);
    chk("t1_frame_cnt",  32'(frame_cnt), 32'd1);
    chk("t1_err_len",    32'(err_len),   32'd0);
    take_frame();
    chk("t1_after_take", 32'(sig_valid), 32'd0);

    // Frame 2: saturation corners, lands in bank 1
    fill_ramp(12'h005);
    stim[1] = 12'h7FF; stim[2] = 12'h800; stim[3] = 12'h07F; stim[4] = 12'hF81;
    send_frame(c_n, 1'b0, 1'b0);
    chk("t2_sig_valid", 32'(sig_valid), 32'd1);
    chk("t2_slot0",     32'(slot(0)),   32'h05);
    chk("t2_sat_7ff",   32'(slot(1)),   32'h7F);
    chk("t2_sat_800",   32'(slot(2)),   32'h81);
    chk("t2_sat_07f",   32'(slot(3)),   32'h7F);
    chk("t2_sat_f81",   32'(slot(4)),   32'h81);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    take_frame();

    // Back-to-back frames with no take until both banks fill
    fill_ramp(12'h001);
    send_frame(c_n, 1'b0, 1'b0);
    chk("t3_ready_one_full", 32'(in_ready), 32'd1);
    fill_ramp(12'h002);
    send_frame(c_n, 1'b0, 1'b0);
    chk("t3_ready_both_full", 32'(in_ready),  32'd0);
    chk("t3_oldest_shown",    32'(slot(0)),   32'h01);
    in_llr = 12'h003; in_last = 1'b0; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_held_ready",     32'(in_ready),  32'd0);
    chk("t3_held_frame_cnt", 32'(frame_cnt), 32'd4);
    take_frame();
    chk("t3_ready_after_take", 32'(in_ready),  32'd1);
    chk("t3_sig_frame2",       32'(slot(0)),   32'h02);
    chk("t3_sig_valid",        32'(sig_valid), 32'd1);
    fill_ramp(12'h003);
    send_frame(c_n, 1'b0, 1'b0);
    chk("t3_frame_cnt",   32'(frame_cnt), 32'd5);
    chk("t3_ready_again", 32'(in_ready),  32'd0);
    take_frame();
    chk("t3_sig_frame3", 32'(slot(0)), 32'h03);

    // Frame end coincides with take of the other bank
    fill_ramp(12'h004);
    send_frame(c_n, 1'b0, 1'b1);
    chk("t4_sig_valid", 32'(sig_valid), 32'd1);
    chk("t4_slot0",     32'(slot(0)),   32'h04);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd6);
    chk("t4_in_ready",  32'(in_ready),  32'd1);
    take_frame();
    chk("t4_empty", 32'(sig_valid), 32'd0);

    // Short frame: in_last on sample 100
    for (int k = 0; k < c_n; k++) stim[k] = 12'h010;
    send_frame(101, 1'b0, 1'b0);
    chk("t5_short_err",       32'(err_len),   32'd1);
    chk("t5_short_frame_cnt", 32'(frame_cnt), 32'd6);
    chk("t5_short_valid",     32'(sig_valid), 32'd0);
    @(posedge clk); #1;
    chk("t5_err_one_cycle", 32'(err_len), 32'd0);
    fill_ramp(12'h007);
    send_frame(c_n, 1'b0, 1'b0);
    chk("t5_clean_valid", 32'(sig_valid), 32'd1);
    chk("t5_clean_slot0", 32'(slot(0)),   32'h07);
    chk("t5_clean_s50",   32'(slot(50)),  32'h81);
    chk("t5_clean_s200",  32'(slot(200)), 32'hA8);
    chk("t5_clean_s350",  32'(slot(350)), 32'h3E);
    chk("t5_clean_err",   32'(err_len),   32'd0);
    chk("t5_clean_cnt",   32'(frame_cnt), 32'd7);
    take_frame();
    // Missing in_last on sample 575
    fill_ramp(12'h008);
    send_frame(c_n, 1'b1, 1'b0);
    chk("t5_nolast_err",   32'(err_len),   32'd1);
    chk("t5_nolast_valid", 32'(sig_valid), 32'd1);
    chk("t5_nolast_slot0", 32'(slot(0)),   32'h08);
    chk("t5_nolast_cnt",   32'(frame_cnt), 32'd8);
    @(posedge clk); #1;
    chk("t5_nolast_err_clr", 32'(err_len), 32'd0);

    // Async reset mid-frame with a frame pending
    fill_ramp(12'h009);
    send_frame(300, 1'b1, 1'b0);
    chk("t6_pending", 32'(sig_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(sig_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready),  32'd1);
    chk("t6_rst_sig",   32'(|sig),      32'd0);
    chk("t6_rst_cnt",   32'(frame_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_ramp(12'h00A);
    send_frame(c_n, 1'b0, 1'b0);
    chk("t6_fresh_valid", 32'(sig_valid), 32'd1);
    chk("t6_fresh_slot0", 32'(slot(0)),   32'h0A);
    chk("t6_fresh_s575",  32'(slot(575)), 32'h7F);
    chk("t6_fresh_s299",  32'(slot(299)), 32'h0B);
    chk("t6_fresh_cnt",   32'(frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
